fetch_mem_arbiter: RTL

Sequences a single shared memory port between the instruction-fetch requester and the load/store (data) requester of the pipelined CPU. Grants one transaction at a time, holds the memory-side request until the memory acknowledges, returns read data through registered per-requester done pulses, and lets an exception flush discard an in-flight fetch result. It sits between the fetch/memory pipeline stages and the unified memory model. The pipeline derives its fetch and data stalls from this block.

---
 rtl/fetch_mem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one memory port between instruction fetch and
// load/store, one transaction at a time, alternating priority on contention.
module fetch_mem_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [DATA_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_done,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_stall,
    input  logic                flush,
    output logic                m_valid,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [DATA_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t state;
    logic   last_d;
    logic   drop;
    logic   i_elig;
    logic   d_elig;
    logic   grant_i;
    logic   grant_d;
    logic   i_kill;

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;
    assign i_elig  = i_req & ~i_done & ~flush;
    assign d_elig  = d_req & ~d_done;
    assign grant_d = d_elig & (~i_elig | ~last_d);
    assign grant_i = i_elig & ~grant_d;
    // a flush landing on the completing cycle still kills the fetch
    assign i_kill  = drop | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            drop    <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        last_d  <= 1'b1;
                        m_valid <= 1'b1;
                        m_we    <= d_we;
                        m_be    <= d_be;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state   <= BUSY_I;
                        last_d  <= 1'b0;
                        drop    <= 1'b0;
                        m_valid <= 1'b1;
                        m_we    <= 1'b0;
                        m_be    <= '1;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                    end
                end
                BUSY_I: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        drop    <= 1'b0;
                        if (!i_kill) begin
                            i_rdata <= m_rdata;
                            i_done  <= 1'b1;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        d_rdata <= m_rdata;
                        d_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
